// File: rtl/jt51_op_acc.sv
// Operator output accumulator: sums carrier operators of a 32-slot frame into L/R, saturates
// and presents one stereo sample per frame. Optional clip counter: `define JT51_ACC_CLIP_CNT_EN.
module jt51_op_acc #(
    parameter int ACC_W = 19,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cen,
    input  logic                    zero,
    input  logic signed [13:0]      op_in,
    input  logic [2:0]              con,
    input  logic [1:0]              rl,
    output logic signed [OUT_W-1:0] left,
    output logic signed [OUT_W-1:0] right,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    ovr_clr,
    output logic [7:0]              clip_cnt
);

    logic [4:0]              cnt_q, cnt_d, slot;
    logic                    carrier;
    logic signed [ACC_W-1:0] term, term_l, term_r;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [ACC_W-1:0] fin_l, fin_r;
    logic signed [OUT_W-1:0] left_q, left_d, right_q, right_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    new_sample;

    // Value fits OUT_W when all bits above the OUT_W sign bit equal the sign.
    function automatic logic is_clip(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0] upper;
        upper = v[ACC_W-1:OUT_W-1];
        return !((upper == '0) || (upper == '1));
    endfunction

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (is_clip(v))
            return v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        else
            return v[OUT_W-1:0];
    endfunction

    always_comb begin
        slot = zero ? 5'd0 : cnt_q;
        case (slot[4:3])
            2'd3:    carrier = 1'b1;
            2'd2:    carrier = (con >= 3'd4);
            2'd1:    carrier = (con >= 3'd5);
            default: carrier = (con == 3'd7);
        endcase
        term   = carrier ? {{(ACC_W-14){op_in[13]}}, op_in} : '0;
        term_l = rl[0] ? term : '0;
        term_r = rl[1] ? term : '0;
        fin_l  = acc_l_q + term_l;
        fin_r  = acc_r_q + term_r;
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        left_d     = left_q;
        right_d    = right_q;
        new_sample = 1'b0;
        if (cen) begin
            cnt_d = slot + 5'd1;
            if (slot == 5'd0) begin
                // A zero mid-frame lands here too, discarding the partial sums.
                acc_l_d = term_l;
                acc_r_d = term_r;
            end else if (slot == 5'd31) begin
                left_d     = sat(fin_l);
                right_d    = sat(fin_r);
                new_sample = 1'b1;
                acc_l_d    = '0;
                acc_r_d    = '0;
            end else begin
                acc_l_d = fin_l;
                acc_r_d = fin_r;
            end
        end
    end

    always_comb begin
        out_valid_d = new_sample | (out_valid_q & ~out_ready);
        overrun_d   = ovr_clr ? 1'b0 : (overrun_q | (new_sample & out_valid_q & ~out_ready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

`ifdef JT51_ACC_CLIP_CNT_EN
    logic       clip_l, clip_r;
    logic [8:0] clip_sum;
    logic [7:0] clip_cnt_q, clip_cnt_d;

    always_comb begin
        clip_l     = is_clip(fin_l);
        clip_r     = is_clip(fin_r);
        clip_sum   = {1'b0, clip_cnt_q} + {8'd0, clip_l} + {8'd0, clip_r};
        clip_cnt_d = clip_cnt_q;
        if (ovr_clr)
            clip_cnt_d = '0;
        else if (new_sample)
            clip_cnt_d = clip_sum[8] ? 8'hFF : clip_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clip_cnt_q <= '0;
        else        clip_cnt_q <= clip_cnt_d;
    end

    assign clip_cnt = clip_cnt_q;
`else
    assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_jt51_op_acc.sv
// Randomized and directed bench for jt51_op_acc against a frame-level reference model.
module tb_jt51_op_acc;

    logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, zero = 1'b0;
    logic out_ready = 1'b1, ovr_clr = 1'b0;
    logic signed [13:0] op_in = '0;
    logic [2:0] con = '0;
    logic [1:0] rl = '0;
    logic signed [15:0] left, right;
    logic out_valid, overrun;
    logic [7:0] clip_cnt;

    int checks = 0, errors = 0;
    bit rnd_ready = 0, rnd_clr = 0, gaps = 0;
    int fop [32];
    int fcon [8];
    int frl [8];

    always #5 clk = ~clk;

    jt51_op_acc #(.ACC_W(19), .OUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .op_in(op_in), .con(con), .rl(rl),
        .left(left), .right(right), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .ovr_clr(ovr_clr), .clip_cnt(clip_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: collects a frame, evaluates it at slot 31
    int m_cnt, m_slot, m_sl, m_sr, m_ncl;
    bit m_new;
    int f_slot[$], f_op[$], f_con[$], f_rl[$];
    int exp_left, exp_right, exp_clip;
    bit exp_valid, exp_ovr;

    function automatic bit carries(input int op, input int c);
        case (op)
            3: return 1;
            2: return c >= 4;
            1: return c >= 5;
            default: return c == 7;
        endcase
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; f_slot.delete(); f_op.delete(); f_con.delete(); f_rl.delete();
            exp_left = 0; exp_right = 0; exp_clip = 0; exp_valid = 0; exp_ovr = 0;
        end else begin
            m_new = 0; m_ncl = 0;
            if (cen) begin
                m_slot = zero ? 0 : m_cnt;
                m_cnt = (m_slot + 1) % 32;
                if (m_slot == 0) begin
                    f_slot.delete(); f_op.delete(); f_con.delete(); f_rl.delete();
                end
                f_slot.push_back(m_slot); f_op.push_back(int'(op_in));
                f_con.push_back(int'(con)); f_rl.push_back(int'(rl));
                if (m_slot == 31) begin
                    m_sl = 0; m_sr = 0;
                    foreach (f_slot[i])
                        if (carries(f_slot[i] / 8, f_con[i])) begin
                            if (f_rl[i] % 2 == 1) m_sl += f_op[i];
                            if (f_rl[i] >= 2)     m_sr += f_op[i];
                        end
                    m_ncl = int'(sat16(m_sl) != m_sl) + int'(sat16(m_sr) != m_sr);
                    exp_left = sat16(m_sl); exp_right = sat16(m_sr);
                    m_new = 1;
                    f_slot.delete(); f_op.delete(); f_con.delete(); f_rl.delete();
                end
            end
            if (ovr_clr) exp_ovr = 0;
            else if (m_new && exp_valid && !out_ready) exp_ovr = 1;
            exp_valid = m_new || (exp_valid && !out_ready);
`ifdef JT51_ACC_CLIP_CNT_EN
            if (ovr_clr) exp_clip = 0;
            else if (m_new) exp_clip = (exp_clip + m_ncl > 255) ? 255 : exp_clip + m_ncl;
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_left", longint'(left), exp_left);
            chk("cyc_right", longint'(right), exp_right);
            chk("cyc_valid", out_valid, exp_valid);
            chk("cyc_overrun", overrun, exp_ovr);
            chk("cyc_clip", clip_cnt, exp_clip);
        end
    end

    // ---------------- stimulus
    task automatic drive_misc();
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        ovr_clr = rnd_clr && ($urandom_range(0, 15) == 0);
    endtask

    task automatic idle(input bit clr = 0);
        int g;
        @(posedge clk); #1;
        g = $urandom_range(0, 16383);
        cen = 0; zero = 1'($urandom_range(0, 1)); op_in = g[13:0];
        drive_misc();
        if (clr) ovr_clr = 1;
    endtask

    task automatic slot_cycle(input bit z, input int op, input int c, input int r);
        if (gaps) repeat ($urandom_range(0, 2)) idle();
        @(posedge clk); #1;
        cen = 1; zero = z; op_in = op[13:0]; con = c[2:0]; rl = r[1:0];
        drive_misc();
    endtask

    task automatic run_slots(input int n);
        for (int s = 0; s < n; s++) slot_cycle(s == 0, fop[s], fcon[s % 8], frl[s % 8]);
    endtask

    task automatic fill(input int op, input int c, input int r);
        for (int s = 0; s < 32; s++) fop[s] = op;
        for (int ch = 0; ch < 8; ch++) begin fcon[ch] = c; frl[ch] = r; end
    endtask

    int clipx, len;

    initial begin
        #1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_left", longint'(left), 0);
        chk("rst_right", longint'(right), 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_clip", clip_cnt, 0);
        rst_n = 1;

        // all carriers, both sides
        fill(100, 7, 3); run_slots(32); idle();
        chk("t1_left", longint'(left), 3200);
        chk("t1_right", longint'(right), 3200);
        chk("t1_valid", out_valid, 1);
        chk("t1_model", exp_left, 3200);

        // con=0: only C2 slots count; left only
        fill(1000, 0, 1);
        for (int s = 0; s < 24; s++) fop[s] = $urandom_range(0, 16383) - 8192;
        run_slots(32); idle();
        chk("t2_left", longint'(left), 8000);
        chk("t2_right", longint'(right), 0);

        // saturation both directions
        idle(1); idle();
`ifdef JT51_ACC_CLIP_CNT_EN
        clipx = 2;
`else
        clipx = 0;
`endif
        fill(8191, 7, 3); run_slots(32); idle();
        chk("t3_pos_left", longint'(left), 32767);
        chk("t3_pos_right", longint'(right), 32767);
        chk("t3_pos_clip", clip_cnt, clipx);
        fill(-8192, 7, 3); run_slots(32); idle();
        chk("t3_neg_left", longint'(left), -32768);
        chk("t3_neg_right", longint'(right), -32768);
        chk("t3_neg_clip", clip_cnt, 2 * clipx);

        // overrun on back-to-back unaccepted samples
        out_ready = 0;
        fill(10, 7, 3); run_slots(32);
        fill(20, 7, 3); run_slots(32); idle();
        chk("t4_left", longint'(left), 640);
        chk("t4_overrun", overrun, 1);
        chk("t4_valid", out_valid, 1);
        idle(1); idle();
        chk("t4_clr", overrun, 0);
        out_ready = 1; idle(); idle();
        chk("t4_drain", out_valid, 0);

        // resync at cnt=12
        fill(999, 7, 3); run_slots(12); idle();
        chk("t5_nosample", out_valid, 0);
        fill(50, 7, 3); run_slots(32); idle();
        chk("t5_left", longint'(left), 1600);
        chk("t5_right", longint'(right), 1600);

        // async reset mid-frame
        fill(77, 7, 3); run_slots(32); idle();
        chk("t6_pre", longint'(left), 2464);
        fill(33, 7, 3); run_slots(10);
        #2 rst_n = 0;
        #1;
        chk("t6_async_left", longint'(left), 0);
        chk("t6_async_right", longint'(right), 0);
        chk("t6_async_valid", out_valid, 0);
        @(posedge clk); #1 rst_n = 1;
        fill(77, 7, 3); run_slots(32); idle();
        chk("t6_left", longint'(left), 2464);

        // randomized frames with cen gaps, random ready and clears
        rnd_ready = 1; rnd_clr = 1; gaps = 1;
        for (int f = 0; f < 60; f++) begin
            for (int ch = 0; ch < 8; ch++) begin
                fcon[ch] = $urandom_range(0, 7);
                frl[ch] = $urandom_range(0, 3);
            end
            for (int s = 0; s < 32; s++)
                if (f % 4 == 3) fop[s] = ($urandom_range(0, 1) != 0) ? 8191 : -8192;
                else fop[s] = $urandom_range(0, 16383) - 8192;
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 31) : 32;
            run_slots(len);
        end
        rnd_ready = 0; rnd_clr = 0; gaps = 0; out_ready = 1;
        repeat (4) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
